// File: rtl/loba_mac_pkg.sv
// loba_mac_pkg
// Shared types and helpers for the LOBA MAC accumulator slice.
//   state_t      : frame FSM states (IDLE, ACC, OUT)
//   sat_max/min  : most positive / most negative value of an aw-bit signed word
//   sext_prod    : sign-extend a pw-bit product held in the low bits of a wide word
// The helpers work in a fixed 64-bit container so they can serve any
// AW/PW up to 64 bits; callers cast the result down to their own width.
package loba_mac_pkg;

    localparam int FW = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    function automatic logic signed [FW-1:0] sat_max(input int aw);
        return (64'sd1 <<< (aw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [FW-1:0] sat_min(input int aw);
        return -(64'sd1 <<< (aw - 1));
    endfunction

    // Push the product's sign bit up to bit 63, then shift back arithmetically.
    function automatic logic signed [FW-1:0] sext_prod(input logic [FW-1:0] prod, input int pw);
        logic [FW-1:0] shifted;
        shifted = prod << (FW - pw);
        return $signed(shifted) >>> (FW - pw);
    endfunction

endpackage

// File: rtl/loba_sat_add.sv
// loba_sat_add
// Combinational saturating signed adder.
//   a, b : AW-bit signed operands
//   y    : a + b clamped to the AW-bit signed range
//   ovf  : high when the clamp was applied
module loba_sat_add
    import loba_mac_pkg::*;
#(
    parameter int AW = 40
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] y,
    output logic          ovf
);

    localparam logic [AW-1:0] MAX_V = AW'(sat_max(AW));
    localparam logic [AW-1:0] MIN_V = AW'(sat_min(AW));

    logic [AW:0] wide_sum;

    // One guard bit: if the top two bits of the AW+1-bit sum disagree the
    // true result left the AW-bit range, and the guard bit gives its sign.
    always_comb begin
        wide_sum = {a[AW-1], a} + {b[AW-1], b};
        ovf      = wide_sum[AW] ^ wide_sum[AW-1];
        if (!ovf) begin
            y = wide_sum[AW-1:0];
        end else if (wide_sum[AW]) begin
            y = MIN_V;
        end else begin
            y = MAX_V;
        end
    end

endmodule

// File: rtl/loba_mac_accum.sv
// loba_mac_accum
// Streaming saturating accumulator for frames of signed LOBA products.
//   clk, rst_n          : clock and asynchronous active-low reset
//   clear               : synchronous abort, drops the current frame/result
//   len                 : frame length in beats (0 means 1), taken on the first beat
//   in_valid/in_ready   : product handshake, in_prod is the signed product
//   out_valid/out_ready : result handshake
//   out_sum             : saturated frame sum, out_ovf: saturation seen in frame
module loba_mac_accum
    import loba_mac_pkg::*;
#(
    parameter int PW = 32,
    parameter int AW = 40,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic [CW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic          out_ovf
);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [CW-1:0] len_q;
    logic          ovf_q;

    logic          beat;
    logic          out_fire;
    logic [CW-1:0] len_eff;
    logic [CW-1:0] cnt_inc;
    logic [AW-1:0] prod_ext;
    logic [AW-1:0] sum;
    logic          add_ovf;

    assign beat     = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign len_eff  = (len == '0) ? CW'(1) : len;
    assign cnt_inc  = cnt + CW'(1);
    assign prod_ext = AW'(sext_prod(FW'(in_prod), PW));

    loba_sat_add #(.AW(AW)) u_sat_add (
        .a   (acc),
        .b   (prod_ext),
        .y   (sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // clear beats every other event, including a beat or out_fire in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (beat) state_next = (len_eff == CW'(1)) ? OUT : ACC;
            ACC:  if (beat && (cnt_inc == len_q)) state_next = OUT;
            OUT:  if (out_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    // OUT is the only state that refuses products; it never bypasses into a new frame.
    always_comb begin
        in_ready  = (state != OUT);
        out_valid = (state == OUT);
    end

    // The first beat restarts the frame from the product itself rather than
    // adding to a stale accumulator; later beats go through the saturating add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (beat) begin
            case (state)
                IDLE: begin
                    len_q <= len_eff;
                    acc   <= prod_ext;
                    cnt   <= CW'(1);
                    ovf_q <= 1'b0;
                end
                ACC: begin
                    acc   <= sum;
                    cnt   <= cnt_inc;
                    ovf_q <= ovf_q | add_ovf;
                end
                default: ;
            endcase
        end
    end

    // acc and ovf_q are frozen while in OUT, so the result is stable under backpressure.
    assign out_sum = acc;
    assign out_ovf = ovf_q;

endmodule

// File: tb/tb_loba_mac_accum.sv
// tb_loba_mac_accum
// Directed bench for loba_mac_accum. Two instances share all inputs: dut_a
// uses the default AW=40, dut_b uses AW=34 so 32-bit products can saturate.
module tb_loba_mac_accum;

    logic               clk;
    logic               rst_n;
    logic               clear;
    logic [7:0]         len;
    logic               in_valid;
    logic [31:0]        in_prod;
    logic               out_ready;

    logic               in_ready_a, out_valid_a, out_ovf_a;
    logic signed [39:0] out_sum_a;
    logic               in_ready_b, out_valid_b, out_ovf_b;
    logic signed [33:0] out_sum_b;

    int compared;
    int mismatched;

    logic signed [31:0] beats [8];

    loba_mac_accum #(.PW(32), .AW(40), .CW(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_prod   (in_prod),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_sum   (out_sum_a),
        .out_ovf   (out_ovf_a)
    );

    loba_mac_accum #(.PW(32), .AW(34), .CW(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_prod   (in_prod),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_sum   (out_sum_b),
        .out_ovf   (out_ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive n beats from beats[], optional idle gap between beats. len is
    // presented on the first beat only and then scrambled to prove it is latched.
    task automatic applyStimulus(input int l, input int n, input bit gap);
        len = 8'(l);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_prod  = beats[i];
            step();
            len      = 8'd1;
            in_valid = 1'b0;
            in_prod  = 32'h0BAD_F00D;
            if (gap && (i < n - 1)) step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; len = 8'd0; in_valid = 1'b0;
        in_prod = 32'd0; out_ready = 1'b1;
        #12;
        compared++;
        if (out_valid_a !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid_a); end
        compared++;
        if (out_sum_a !== 40'sd0) begin mismatched++; $display("[TB] FAIL reset_out_sum: got %0d expected 0", out_sum_a); end
        compared++;
        if (out_ovf_a !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_ovf: got %0b expected 0", out_ovf_a); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        compared++;
        if (in_ready_a !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready_a); end
    endtask

    task automatic test_basic_frame();
        beats = '{32'sd10, -32'sd3, 32'sd7, 32'sd100, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
        out_ready = 1'b1;
        applyStimulus(4, 3, 1'b0);
        compared++;
        if (out_valid_a !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_early_valid: got %0b expected 0", out_valid_a); end
        len = 8'd1; in_valid = 1'b1; in_prod = beats[3];
        step();
        in_valid = 1'b0;
        compared++;
        if (out_valid_a !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_out_valid: got %0b expected 1", out_valid_a); end
        compared++;
        if (out_sum_a !== 40'sd114) begin mismatched++; $display("[TB] FAIL basic_out_sum: got %0d expected 114", out_sum_a); end
        compared++;
        if (out_ovf_a !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_out_ovf: got %0b expected 0", out_ovf_a); end
        compared++;
        if (in_ready_a !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_in_ready_out: got %0b expected 0", in_ready_a); end
        step();
        compared++;
        if (in_ready_a !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_in_ready_after: got %0b expected 1", in_ready_a); end
        compared++;
        if (out_valid_a !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_valid_after: got %0b expected 0", out_valid_a); end
    endtask

    task automatic test_saturation();
        beats = '{32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF,
                  32'sh7FFFFFFF, 32'sd0, 32'sd0, 32'sd0};
        applyStimulus(5, 5, 1'b0);
        compared++;
        if (out_sum_b !== 34'sh1FFFFFFFF) begin mismatched++; $display("[TB] FAIL sat_pos_sum: got %0d expected 8589934591", out_sum_b); end
        compared++;
        if (out_ovf_b !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_pos_ovf: got %0b expected 1", out_ovf_b); end
        compared++;
        if (out_sum_a !== 40'sd10737418235) begin mismatched++; $display("[TB] FAIL wide_pos_sum: got %0d expected 10737418235", out_sum_a); end
        compared++;
        if (out_ovf_a !== 1'b0) begin mismatched++; $display("[TB] FAIL wide_pos_ovf: got %0b expected 0", out_ovf_a); end
        step();
        beats[0] = -32'sd1;
        applyStimulus(1, 1, 1'b0);
        compared++;
        if (out_valid_b !== 1'b1) begin mismatched++; $display("[TB] FAIL len1_valid: got %0b expected 1", out_valid_b); end
        compared++;
        if (out_sum_b !== -34'sd1) begin mismatched++; $display("[TB] FAIL len1_sum: got %0d expected -1", out_sum_b); end
        compared++;
        if (out_ovf_b !== 1'b0) begin mismatched++; $display("[TB] FAIL len1_ovf_cleared: got %0b expected 0", out_ovf_b); end
        step();
    endtask

    task automatic test_backpressure();
        beats = '{32'sd5, 32'sd6, 32'sd7, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
        out_ready = 1'b0;
        applyStimulus(3, 3, 1'b1);
        compared++;
        if (out_sum_a !== 40'sd18) begin mismatched++; $display("[TB] FAIL gap_sum: got %0d expected 18", out_sum_a); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_prod  = 32'd1000;
            step();
            compared++;
            if (out_valid_a !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_valid[%0d]: got %0b expected 1", c, out_valid_a); end
            compared++;
            if (out_sum_a !== 40'sd18) begin mismatched++; $display("[TB] FAIL hold_sum[%0d]: got %0d expected 18", c, out_sum_a); end
            compared++;
            if (out_ovf_a !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_ovf[%0d]: got %0b expected 0", c, out_ovf_a); end
            compared++;
            if (in_ready_a !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_in_ready[%0d]: got %0b expected 0", c, in_ready_a); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        compared++;
        if (out_valid_a !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_release: got %0b expected 0", out_valid_a); end
    endtask

    task automatic test_len_zero_and_neg_sat();
        beats[0] = -32'sd42;
        applyStimulus(0, 1, 1'b0);
        compared++;
        if (out_valid_a !== 1'b1) begin mismatched++; $display("[TB] FAIL len0_valid: got %0b expected 1", out_valid_a); end
        compared++;
        if (out_sum_a !== -40'sd42) begin mismatched++; $display("[TB] FAIL len0_sum: got %0d expected -42", out_sum_a); end
        step();
        beats = '{32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000,
                  32'sh80000000, 32'sd0, 32'sd0, 32'sd0};
        applyStimulus(5, 5, 1'b0);
        compared++;
        if (out_sum_b !== 34'sh200000000) begin mismatched++; $display("[TB] FAIL sat_neg_sum: got %0d expected -8589934592", out_sum_b); end
        compared++;
        if (out_ovf_b !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_neg_ovf: got %0b expected 1", out_ovf_b); end
        compared++;
        if (out_sum_a !== -40'sd10737418240) begin mismatched++; $display("[TB] FAIL wide_neg_sum: got %0d expected -10737418240", out_sum_a); end
        step();
    endtask

    task automatic test_clear();
        beats = '{32'sd1, 32'sd2, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
        applyStimulus(4, 2, 1'b0);
        in_valid = 1'b1; in_prod = 32'd3; clear = 1'b1;
        step();
        in_valid = 1'b0; clear = 1'b0;
        compared++;
        if (out_valid_a !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_no_valid: got %0b expected 0", out_valid_a); end
        compared++;
        if (out_sum_a !== 40'sd0) begin mismatched++; $display("[TB] FAIL clear_acc: got %0d expected 0", out_sum_a); end
        step();
        compared++;
        if (out_valid_a !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_still_idle: got %0b expected 0", out_valid_a); end
        beats = '{32'sd4, 32'sd5, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
        applyStimulus(2, 2, 1'b0);
        compared++;
        if (out_valid_a !== 1'b1) begin mismatched++; $display("[TB] FAIL after_clear_valid: got %0b expected 1", out_valid_a); end
        compared++;
        if (out_sum_a !== 40'sd9) begin mismatched++; $display("[TB] FAIL after_clear_sum: got %0d expected 9", out_sum_a); end
        step();
    endtask

    task automatic test_async_reset();
        beats = '{32'sd3, 32'sd4, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
        out_ready = 1'b0;
        applyStimulus(2, 2, 1'b0);
        compared++;
        if (out_valid_a !== 1'b1) begin mismatched++; $display("[TB] FAIL prereset_valid: got %0b expected 1", out_valid_a); end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (out_valid_a !== 1'b0) begin mismatched++; $display("[TB] FAIL async_valid: got %0b expected 0", out_valid_a); end
        compared++;
        if (out_sum_a !== 40'sd0) begin mismatched++; $display("[TB] FAIL async_sum: got %0d expected 0", out_sum_a); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        beats[0] = 32'sd7;
        applyStimulus(1, 1, 1'b0);
        compared++;
        if (out_valid_a !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_valid: got %0b expected 1", out_valid_a); end
        compared++;
        if (out_sum_a !== 40'sd7) begin mismatched++; $display("[TB] FAIL post_reset_sum: got %0d expected 7", out_sum_a); end
        step();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_basic_frame();
        test_saturation();
        test_backpressure();
        test_len_zero_and_neg_sat();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
